xirq_ctrl: RTL and testbench



---
 rtl/xirq_ctrl_pkg.sv | 22 ++
 rtl/xirq_ctrl_xencdr.sv | 24 ++
 rtl/xirq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_xirq_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xirq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// xirq_ctrl_pkg
// Shared definitions for the xirq_ctrl interrupt controller: FSM state type
// and configuration register addresses.
// ----------------------------------------------------------------------------
package xirq_ctrl_pkg;

    // Values are visible to software through STATUS[9:8].
    typedef enum logic [1:0] {
        XIRQ_IDLE    = 2'd0,
        XIRQ_REQ     = 2'd1,
        XIRQ_SERVICE = 2'd2
    } xirq_state_e;

    localparam logic [1:0] XIRQ_CFG_ENABLE  = 2'd0;
    localparam logic [1:0] XIRQ_CFG_PENDING = 2'd1;
    localparam logic [1:0] XIRQ_CFG_STATUS  = 2'd2;

    // Round-robin history starts at the top source so source 0 leads after reset.
    localparam logic [4:0] XIRQ_LAST_ID_RST = 5'd31;

endpackage

// File: rtl/xirq_ctrl_xencdr.sv
// ----------------------------------------------------------------------------
// xencdr
// 32-bit lowest-set-bit priority encoder. Returns the index of the lowest set
// bit of din, or 0 when din is all zeros (callers qualify with |din).
// Ports:
//   din  in  32  request vector
//   enc  out 5   index of lowest set bit
// ----------------------------------------------------------------------------
module xencdr (
    input  logic [31:0] din,
    output logic [4:0]  enc
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        enc = '0;
        for (int unsigned i = 32; i > 0; i--) begin
            if (din[i-1]) begin
                enc = 5'(i - 1);
            end
        end
    end

endmodule

// File: rtl/xirq_ctrl.sv
// ----------------------------------------------------------------------------
// xirq_ctrl
// Interrupt controller/arbiter between NUM_SRC external interrupt lines and
// the core trap logic. Rising edges are captured into PENDING, masked by
// ENABLE, and one winner is offered to the core through a req/ack/done
// handshake (one interrupt in service, no nesting).
//
// Build option: define XIRQ_ROUND_ROBIN_EN for round-robin arbitration (the
// source just served gets lowest priority); otherwise lowest index wins.
//
// Ports:
//   clk         in   1        clock, rising edge
//   rst         in   1        asynchronous active-high reset
//   irq_src     in   NUM_SRC  raw interrupt lines, rising-edge sensitive
//   cfg_we      in   1        config write strobe
//   cfg_addr    in   2        0=ENABLE 1=PENDING(W1C) 2=STATUS 3=reserved
//   cfg_wdata   in   32       config write data
//   cfg_rdata   out  32       combinational read of cfg_addr
//   irq_req     out  1        interrupt request to core
//   irq_id      out  5        winning source index
//   irq_ack     in   1        core accepts request
//   irq_done    in   1        core finished handler
//   irq_active  out  1        interrupt in service
// ----------------------------------------------------------------------------
module xirq_ctrl
    import xirq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               irq_req,
    output logic [4:0]         irq_id,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               irq_active
);

    xirq_state_e        state, state_nx;
    logic [4:0]         id_nx;
    logic [4:0]         winner;
    logic               take_ack;

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] cfg_clr;
    logic [NUM_SRC-1:0] fsm_clr;
    logic [31:0]        cand32;
    logic [31:0]        ack_onehot;
    logic               any;
    logic               cand_held;

    assign rise      = irq_src & ~src_q;
    assign cand      = pending & enable;
    assign cand32    = 32'(cand);
    assign any       = |cand;
    assign cand_held = cand32[irq_id];

    assign ack_onehot = 32'd1 << irq_id;
    assign cfg_clr    = (cfg_we && cfg_addr == XIRQ_CFG_PENDING) ? cfg_wdata[NUM_SRC-1:0] : '0;
    assign fsm_clr    = take_ack ? ack_onehot[NUM_SRC-1:0] : '0;

`ifdef XIRQ_ROUND_ROBIN_EN
    logic [4:0]  last_id;
    logic [4:0]  enc_hi;
    logic [4:0]  enc_all;
    logic [32:0] served_mask;
    logic [32:0] hi;

    // 33-bit so last_id=31 masks everything and hi collapses to zero.
    assign served_mask = (33'd2 << last_id) - 33'd1;
    assign hi          = {1'b0, cand32} & ~served_mask;

    xencdr u_enc_hi  (.din(hi[31:0]), .enc(enc_hi));
    xencdr u_enc_all (.din(cand32),   .enc(enc_all));

    assign winner = (|hi) ? enc_hi : enc_all;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id <= XIRQ_LAST_ID_RST;
        end else if (take_ack) begin
            last_id <= irq_id;
        end
    end
`else
    xencdr u_enc (.din(cand32), .enc(winner));
`endif

    always_comb begin
        state_nx = state;
        id_nx    = irq_id;
        take_ack = 1'b0;
        case (state)
            XIRQ_IDLE: begin
                if (any) begin
                    state_nx = XIRQ_REQ;
                    id_nx    = winner;
                end
            end
            XIRQ_REQ: begin
                // Held id is never preempted; it is only withdrawn when it
                // stops being a candidate (disabled or cleared by software).
                if (irq_ack) begin
                    state_nx = XIRQ_SERVICE;
                    take_ack = 1'b1;
                end else if (!cand_held) begin
                    state_nx = XIRQ_IDLE;
                end
            end
            XIRQ_SERVICE: begin
                if (irq_done) begin
                    state_nx = XIRQ_IDLE;
                end
            end
            default: begin
                state_nx = XIRQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q   <= '0;
            pending <= '0;
            enable  <= '0;
            state   <= XIRQ_IDLE;
            irq_id  <= '0;
        end else begin
            src_q   <= irq_src;
            // New edge beats any clear on the same bit.
            pending <= (pending & ~(cfg_clr | fsm_clr)) | rise;
            if (cfg_we && cfg_addr == XIRQ_CFG_ENABLE) begin
                enable <= cfg_wdata[NUM_SRC-1:0];
            end
            state   <= state_nx;
            irq_id  <= id_nx;
        end
    end

    assign irq_req    = (state == XIRQ_REQ);
    assign irq_active = (state == XIRQ_SERVICE);

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            XIRQ_CFG_ENABLE:  cfg_rdata = 32'(enable);
            XIRQ_CFG_PENDING: cfg_rdata = 32'(pending);
            XIRQ_CFG_STATUS:  cfg_rdata = {22'b0, state, 3'b0, irq_id};
            default:          cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_xirq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_xirq_ctrl
// Self-checking bench for xirq_ctrl. A reference model updated on each clock
// edge pushes expected per-cycle outputs, grant ids and register reads into
// queues; a negedge monitor pops and compares. Directed scenarios are followed
// by a randomized run, then a NUM_SRC=8 instance is exercised.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xirq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] irq_src;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        irq_req;
    logic [4:0]  irq_id;
    logic        irq_ack;
    logic        irq_done;
    logic        irq_active;

    logic [7:0]  src8;
    logic        we8;
    logic [1:0]  addr8;
    logic [31:0] wdata8;
    logic [31:0] rdata8;
    logic        req8;
    logic [4:0]  id8;
    logic        ack8;
    logic        done8;
    logic        act8;

    xirq_ctrl #(.NUM_SRC(32)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack),
        .irq_done(irq_done), .irq_active(irq_active)
    );

    xirq_ctrl #(.NUM_SRC(8)) dut8 (
        .clk(clk), .rst(rst), .irq_src(src8), .cfg_we(we8),
        .cfg_addr(addr8), .cfg_wdata(wdata8), .cfg_rdata(rdata8),
        .irq_req(req8), .irq_id(id8), .irq_ack(ack8),
        .irq_done(done8), .irq_active(act8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic miss(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not observed in time at %0t", nm, $time);
    endtask

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_SVC  = 2;

    int          m_phase;
    logic [4:0]  m_id;
    logic [4:0]  m_last;
    logic [31:0] m_pend;
    logic [31:0] m_en;
    logic [31:0] m_srcq;

    typedef struct packed {
        logic       req;
        logic       act;
        logic [4:0] id;
    } obs_t;

    obs_t        obs_q[$];
    logic [4:0]  grant_q[$];
    logic [31:0] rd_q[$];
    logic        rd_valid = 1'b0;

    // Winner = first candidate found scanning cyclically from the search start.
    function automatic logic [4:0] pick(input logic [31:0] c, input logic [4:0] last);
        int unsigned start;
`ifdef XIRQ_ROUND_ROBIN_EN
        start = (int'(last) + 1) % 32;
`else
        start = 0;
`endif
        for (int unsigned k = 0; k < 32; k++) begin
            if (c[(start + k) % 32]) return 5'((start + k) % 32);
        end
        return 5'd0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_en;
            2'd1:    return m_pend;
            2'd2:    return {22'b0, 2'(m_phase), 3'b0, m_id};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : ref_model
        logic [31:0] cand;
        logic [31:0] clr;
        logic [31:0] rise;
        obs_t        o;
        if (rst) begin
            m_phase = P_IDLE;
            m_id    = 5'd0;
            m_last  = 5'd31;
            m_pend  = 32'd0;
            m_en    = 32'd0;
            m_srcq  = 32'd0;
            obs_q.delete();
            grant_q.delete();
        end else begin
            rise = irq_src & ~m_srcq;
            clr  = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : 32'd0;
            cand = m_pend & m_en;
            if (m_phase == P_IDLE) begin
                if (cand != 32'd0) begin
                    m_id    = pick(cand, m_last);
                    m_phase = P_REQ;
                    grant_q.push_back(m_id);
                end
            end else if (m_phase == P_REQ) begin
                if (irq_ack) begin
                    clr[m_id] = 1'b1;
                    m_last    = m_id;
                    m_phase   = P_SVC;
                end else if (!cand[m_id]) begin
                    m_phase = P_IDLE;
                end
            end else if (irq_done) begin
                m_phase = P_IDLE;
            end
            m_pend = (m_pend & ~clr) | rise;
            if (cfg_we && cfg_addr == 2'd0) m_en = cfg_wdata;
            m_srcq = irq_src;
        end
        o.req = (m_phase == P_REQ);
        o.act = (m_phase == P_SVC);
        o.id  = m_id;
        obs_q.push_back(o);
    end

    // ---------------- monitor ----------------
    logic prev_req = 1'b0;

    always @(negedge clk) begin : monitor
        obs_t e;
        if (obs_q.size() != 0) begin
            e = obs_q.pop_front();
            chk("irq_req", irq_req, e.req);
            chk("irq_active", irq_active, e.act);
            if (e.req || e.act) chk("irq_id", irq_id, e.id);
        end
        if (irq_req && !prev_req) begin
            if (grant_q.size() == 0) miss("grant_expected");
            else chk("grant_id", irq_id, grant_q.pop_front());
        end
        prev_req = irq_req;
        if (rd_valid) begin
            if (rd_q.size() == 0) miss("rd_expected");
            else chk("cfg_rdata", cfg_rdata, rd_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [31:0] src, input logic we, input logic [1:0] a,
                         input logic [31:0] wd, input logic ack, input logic done, input logic rd);
        irq_src   = src;
        cfg_we    = we;
        cfg_addr  = a;
        cfg_wdata = wd;
        irq_ack   = ack;
        irq_done  = done;
        if (rd) rd_q.push_back(exp_rd(a));
        rd_valid  = rd;
    endtask

    task automatic cyc(input logic [31:0] src, input logic we, input logic [1:0] a,
                       input logic [31:0] wd, input logic ack, input logic done, input logic rd);
        @(posedge clk);
        #1;
        drive(src, we, a, wd, ack, done, rd);
    endtask

    task automatic idle(input logic [31:0] src);
        cyc(src, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(32'd0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_req(input string nm, input logic [31:0] src);
        int unsigned k;
        k = 0;
        while (!irq_req && k < 20) begin
            idle(src);
            k++;
        end
        if (!irq_req) miss(nm);
    endtask

    task automatic serve(input logic [31:0] src);
        cyc(src, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        cyc(src, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] src_n;
        logic [31:0] wd;
        logic [1:0]  a;
        logic        we;
        logic        ack;
        logic        done;
        logic        rd;
        int unsigned k;

        rst = 1'b1;
        drive(32'd0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        src8 = '0; we8 = 1'b0; addr8 = 2'd0; wdata8 = '0; ack8 = 1'b0; done8 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", irq_req, 1'b0);
        chk("rst_active", irq_active, 1'b0);
        chk("rst_id", irq_id, 5'd0);
        rst = 1'b0;
        cyc(32'd0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc(32'd0, 1'b0, 2'd1, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc(32'd0, 1'b0, 2'd2, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc(32'd0, 1'b0, 2'd3, 32'd0, 1'b0, 1'b0, 1'b1);

        // Single source, latency and handshake
        do_reset();
        cyc(32'd0, 1'b1, 2'd0, 32'h6, 1'b0, 1'b0, 1'b0);
        idle(32'h4);
        idle(32'h0);
        chk("t1_req_early", irq_req, 1'b0);
        idle(32'h0);
        chk("t1_req", irq_req, 1'b1);
        chk("t1_id", irq_id, 5'd2);
        cyc(32'h0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        cyc(32'h0, 1'b0, 2'd1, 32'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("t1_active", irq_active, 1'b1);
        chk("t1_pend_clr", cfg_rdata, 32'h0);
        cyc(32'h0, 1'b0, 2'd2, 32'd0, 1'b0, 1'b1, 1'b1);
        idle(32'h0);
        chk("t1_idle_act", irq_active, 1'b0);
        chk("t1_idle_req", irq_req, 1'b0);

        // Simultaneous arrivals, after serving source 7
        do_reset();
        cyc(32'd0, 1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        idle(32'h80);
        wait_req("t2_req7", 32'h80);
        chk("t2_id7", irq_id, 5'd7);
        serve(32'h80);
        idle(32'h0);
        idle(32'h220);
        wait_req("t2_req_a", 32'h220);
`ifdef XIRQ_ROUND_ROBIN_EN
        chk("t2_first", irq_id, 5'd9);
`else
        chk("t2_first", irq_id, 5'd5);
`endif
        serve(32'h220);
        wait_req("t2_req_b", 32'h220);
`ifdef XIRQ_ROUND_ROBIN_EN
        chk("t2_second", irq_id, 5'd5);
`else
        chk("t2_second", irq_id, 5'd9);
`endif
        serve(32'h220);

        // Withdrawal when the held source is disabled
        do_reset();
        cyc(32'd0, 1'b1, 2'd0, 32'h10, 1'b0, 1'b0, 1'b0);
        idle(32'h10);
        wait_req("t3_req", 32'h10);
        chk("t3_id", irq_id, 5'd4);
        cyc(32'h10, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(32'h10);
        idle(32'h10);
        chk("t3_withdrawn", irq_req, 1'b0);
        cyc(32'h10, 1'b0, 2'd1, 32'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("t3_pend4", cfg_rdata & 32'h10, 32'h10);
        cyc(32'h10, 1'b0, 2'd2, 32'd0, 1'b0, 1'b0, 1'b1);

        // W1C versus simultaneous rise: set wins; plain W1C clears
        do_reset();
        idle(32'h8);
        idle(32'h0);
        cyc(32'h8, 1'b1, 2'd1, 32'h8, 1'b0, 1'b0, 1'b0);
        cyc(32'h8, 1'b0, 2'd1, 32'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("t4_set_wins", cfg_rdata, 32'h8);
        cyc(32'h8, 1'b1, 2'd1, 32'h8, 1'b0, 1'b0, 1'b0);
        cyc(32'h8, 1'b0, 2'd1, 32'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("t4_w1c", cfg_rdata, 32'h0);

        // Asynchronous reset during service
        do_reset();
        cyc(32'd0, 1'b1, 2'd0, 32'h2, 1'b0, 1'b0, 1'b0);
        idle(32'h2);
        idle(32'hA);
        wait_req("t5_req", 32'hA);
        cyc(32'hA, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(32'hA);
        chk("t5_in_service", irq_active, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_act", irq_active, 1'b0);
        chk("t5_rst_req", irq_req, 1'b0);
        cfg_addr = 2'd0;
        #1;
        chk("t5_rst_en", cfg_rdata, 32'h0);
        cfg_addr = 2'd1;
        #1;
        chk("t5_rst_pend", cfg_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            src_n = irq_src ^ ($urandom & $urandom & $urandom & $urandom);
            we    = ($urandom_range(0, 9) == 0);
            a     = 2'($urandom_range(0, 3));
            wd    = (a == 2'd0) ? ($urandom | $urandom) : ($urandom & $urandom);
            ack   = (m_phase == P_REQ) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
            done  = (m_phase == P_SVC) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 31) == 0);
            rd    = ($urandom_range(0, 1) == 1);
            drive(src_n, we, a, wd, ack, done, rd);
        end
        idle(32'd0);

        // Eight-source instance
        @(posedge clk);
        #1;
        we8 = 1'b1; addr8 = 2'd0; wdata8 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        we8 = 1'b0; src8 = 8'h80;
        k = 0;
        while (!req8 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!req8) miss("t6_req");
        chk("t6_id", id8, 5'd7);
        addr8 = 2'd2;
        #1;
        chk("t6_status", rdata8, 32'h0000_0107);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
